// File: rtl/eae_seq_pkg.sv
// Shared CPU definitions: extended arithmetic element (EAE) operation codes.
package CPU_Definitions;

  typedef enum logic [2:0] {
    EAE_MUL = 3'd0,
    EAE_DVI = 3'd1,
    EAE_SHL = 3'd2,
    EAE_ASR = 3'd3,
    EAE_LSR = 3'd4
  } eae_op_t;

endpackage

// File: rtl/eae_seq_if.sv
// Request/result bundle between a CPU core (master) and the EAE sequencer (slave).
interface eae_seq_if
  import CPU_Definitions::*;
#(
  parameter int WIDTH = 12
) ();

  logic             start;
  eae_op_t          op;
  logic [WIDTH-1:0] ac_in;
  logic [WIDTH-1:0] mq_in;
  logic [WIDTH-1:0] operand;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ac_out;
  logic [WIDTH-1:0] mq_out;
  logic             link_out;

  modport master (
    output start, op, ac_in, mq_in, operand,
    input  busy, done, ac_out, mq_out, link_out
  );

  modport slave (
    input  start, op, ac_in, mq_in, operand,
    output busy, done, ac_out, mq_out, link_out
  );

endinterface

// File: rtl/eae_seq.sv
// Multi-cycle EAE sequencer: shift-add multiply, restoring divide and
// double-word shifts on {AC,MQ}, one bit per clock.
module eae_seq
  import CPU_Definitions::*;
#(
  parameter int WIDTH = 12,
  parameter int CNT_W = $clog2(2*WIDTH+1)
) (
  input logic      clock,
  input logic      reset,
  eae_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2*WIDTH);
  localparam logic [CNT_W-1:0] CNT_WRD = CNT_W'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic             busy_r, done_r, link_out_r;
  logic [WIDTH-1:0] ac_out_r, mq_out_r;

  eae_op_t          op_r;
  logic [WIDTH-1:0] ac_r, mq_r, m_r;
  logic             link_r;
  logic [CNT_W-1:0] cnt_r;

  logic [CNT_W-1:0] shcnt, n_start;
  logic             dvi_ovf;

  always_comb begin
    shcnt   = (bus.operand[CNT_W-1:0] > CNT_MAX) ? CNT_MAX : bus.operand[CNT_W-1:0];
    dvi_ovf = (bus.ac_in >= bus.operand);
    case (bus.op)
      EAE_MUL:                   n_start = CNT_WRD;
      EAE_DVI:                   n_start = dvi_ovf ? '0 : CNT_WRD;
      EAE_SHL, EAE_ASR, EAE_LSR: n_start = shcnt;
      default:                   n_start = '0;
    endcase
  end

  // One WIDTH+1-bit adder serves both multiply (add) and divide (trial subtract);
  // for subtraction the extra carry bit set means no borrow.
  logic [WIDTH:0]   add_a, add_b, a_shl;
  logic             add_sub;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] ac_nx, mq_nx;
  logic             link_nx;

  always_comb begin
    a_shl   = {ac_r, mq_r[WIDTH-1]};
    add_sub = (op_r == EAE_DVI);
    add_a   = add_sub ? a_shl : {1'b0, ac_r};
    add_b   = {1'b0, m_r};
    sum     = {1'b0, add_a} + {1'b0, add_b ^ {(WIDTH+1){add_sub}}}
            + {{(WIDTH+1){1'b0}}, add_sub};
    ac_nx   = ac_r;
    mq_nx   = mq_r;
    link_nx = link_r;
    case (op_r)
      EAE_MUL: begin
        if (mq_r[0]) {ac_nx, mq_nx} = {sum[WIDTH:0], mq_r[WIDTH-1:1]};
        else         {ac_nx, mq_nx} = {1'b0, ac_r, mq_r[WIDTH-1:1]};
      end
      EAE_DVI: begin
        ac_nx = sum[WIDTH+1] ? sum[WIDTH-1:0] : a_shl[WIDTH-1:0];
        mq_nx = {mq_r[WIDTH-2:0], sum[WIDTH+1]};
      end
      EAE_SHL: {link_nx, ac_nx, mq_nx} = {ac_r, mq_r, 1'b0};
      EAE_LSR: {ac_nx, mq_nx, link_nx} = {1'b0, ac_r, mq_r};
      EAE_ASR: {ac_nx, mq_nx, link_nx} = {ac_r[WIDTH-1], ac_r, mq_r};
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ac_out_r   <= '0;
      mq_out_r   <= '0;
      link_out_r <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          ac_r   <= ac_nx;
          mq_r   <= mq_nx;
          link_r <= link_nx;
          cnt_r  <= cnt_r - 1'b1;
          if (cnt_r == CNT_W'(1)) begin
            state      <= S_DONE;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            ac_out_r   <= ac_nx;
            mq_out_r   <= mq_nx;
            link_out_r <= link_nx;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (bus.start) begin
            op_r   <= bus.op;
            ac_r   <= bus.ac_in;
            mq_r   <= bus.mq_in;
            m_r    <= bus.operand;
            link_r <= 1'b0;
            cnt_r  <= n_start;
            // Zero-iteration cases (DVI overflow, count 0, unknown op) finish at accept.
            if (n_start == '0) begin
              state      <= S_DONE;
              done_r     <= 1'b1;
              ac_out_r   <= bus.ac_in;
              mq_out_r   <= bus.mq_in;
              link_out_r <= (bus.op == EAE_DVI);
            end else begin
              state  <= S_RUN;
              busy_r <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.ac_out   = ac_out_r;
  assign bus.mq_out   = mq_out_r;
  assign bus.link_out = link_out_r;

endmodule

// File: tb/tb_eae_seq.sv
// Bench for eae_seq (WIDTH=12): directed operations with literal expectations
// plus a cycle-by-cycle comparison against an arithmetic reference model.
module tb_eae_seq;
  import CPU_Definitions::*;

  localparam int W = 12;

  logic clock;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  eae_seq_if #(.WIDTH(W)) bus ();

  eae_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference arithmetic on the 24-bit {AC,MQ} value.
  function automatic void model(input int o, input logic [W-1:0] a, m, d,
                                output logic [W-1:0] ra, rm, output logic rl, output int n);
    logic [2*W-1:0]        v, q, r;
    logic [47:0]           p, t;
    logic signed [47:0]    s;
    int                    c;
    v = {a, m}; ra = a; rm = m; rl = 1'b0; n = 0;
    c = (int'(d[4:0]) > 2*W) ? 2*W : int'(d[4:0]);
    case (o)
      0: begin
        p = 48'(m) * 48'(d) + 48'(a);
        {ra, rm} = p[2*W-1:0];
        n = W;
      end
      1: begin
        if (a >= d) rl = 1'b1;
        else begin
          q = v / {12'b0, d};
          r = v % {12'b0, d};
          ra = r[W-1:0]; rm = q[W-1:0]; n = W;
        end
      end
      2: if (c > 0) begin
        t = {24'b0, v} << c;
        {ra, rm} = t[2*W-1:0]; rl = t[2*W]; n = c;
      end
      3: if (c > 0) begin
        s = {v, 24'b0};
        s = s >>> c;
        {ra, rm} = s[47:24]; rl = s[23]; n = c;
      end
      4: if (c > 0) begin
        t = {v, 24'b0} >> c;
        {ra, rm} = t[47:24]; rl = t[23]; n = c;
      end
      default: ;
    endcase
  endfunction

  // Timing model: accepted op keeps busy for N cycles, then a one-cycle done with results.
  bit             m_live = 0;
  bit             m_busy, m_done, m_lk, p_lk;
  logic [W-1:0]   m_ac, m_mq, p_ac, p_mq;
  int             m_left;

  always @(posedge clock) begin
    int n;
    if (reset) begin
      m_live = 1; m_busy = 0; m_done = 0; m_ac = '0; m_mq = '0; m_lk = 0; m_left = 0;
    end else if (m_live) begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_ac = p_ac; m_mq = p_mq; m_lk = p_lk;
        end
      end else begin
        m_done = 0;
        if (bus.start === 1'b1) begin
          model(int'(bus.op), bus.ac_in, bus.mq_in, bus.operand, p_ac, p_mq, p_lk, n);
          if (n == 0) begin
            m_done = 1; m_ac = p_ac; m_mq = p_mq; m_lk = p_lk;
          end else begin
            m_busy = 1; m_left = n;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_live)
      check("cycle busy/done/ac/mq/link",
            64'({bus.busy, bus.done, bus.ac_out, bus.mq_out, bus.link_out}),
            64'({m_busy, m_done, m_ac, m_mq, m_lk}));
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, m, d,
                       input logic [W-1:0] e_ac, e_mq, input logic e_lk,
                       input int e_lat, input int poke, input string nm);
    int lat, bcnt;
    bus.start = 1'b1; bus.op = eae_op_t'(o);
    bus.ac_in = a; bus.mq_in = m; bus.operand = d;
    tick();
    bus.start = 1'b0; bus.ac_in = ~a; bus.mq_in = ~m; bus.operand = ~d;
    lat = 1; bcnt = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (bus.busy === 1'b1) bcnt++;
      if (lat == poke) begin
        bus.start = 1'b1; bus.op = EAE_DVI;
        bus.ac_in = 12'd0; bus.mq_in = 12'd1000; bus.operand = 12'd7;
      end else bus.start = 1'b0;
      tick();
      lat++;
    end
    bus.start = 1'b0;
    check({nm, " latency"}, 64'(lat), 64'(e_lat));
    check({nm, " busy cycles"}, 64'(bcnt), 64'(e_lat - 1));
    check({nm, " ac_out"}, 64'(bus.ac_out), 64'(e_ac));
    check({nm, " mq_out"}, 64'(bus.mq_out), 64'(e_mq));
    check({nm, " link_out"}, 64'(bus.link_out), 64'(e_lk));
  endtask

  initial begin
    int dn;
    reset = 1'b1; bus.start = 1'b0; bus.op = EAE_MUL;
    bus.ac_in = '0; bus.mq_in = '0; bus.operand = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset state", 64'({bus.busy, bus.done, bus.ac_out, bus.mq_out, bus.link_out}), 64'(0));
    reset = 1'b0;
    tick();

    do_op(3'd0, 12'd0,   12'd100, 12'd50,  12'd1,   12'd904, 1'b0, 13, 0, "mul 100*50");
    tick();
    do_op(3'd0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 1'b0, 13, 0, "mul all-ones");
    tick();
    do_op(3'd0, 12'h0AB, 12'h123, 12'h045, 12'h004, 12'hF1A, 1'b0, 13, 0, "mul with addend");
    tick();
    do_op(3'd1, 12'd0,   12'd1000, 12'd7,  12'd6,   12'd142, 1'b0, 13, 0, "dvi 1000/7");
    // SHL starts in the DONE cycle of the divide: back-to-back.
    do_op(3'd2, 12'h801, 12'h800, 12'd1,   12'h003, 12'h000, 1'b1, 2,  0, "shl 1 back-to-back");
    tick();
    do_op(3'd1, 12'd5,   12'd0,   12'd5,   12'd5,   12'd0,   1'b1, 1,  0, "dvi overflow");
    tick();
    do_op(3'd1, 12'h123, 12'h456, 12'd0,   12'h123, 12'h456, 1'b1, 1,  0, "dvi by zero");
    tick();
    do_op(3'd1, 12'd5,   12'd0,   12'd7,   12'd5,   12'hB6D, 1'b0, 13, 0, "dvi 20480/7");
    tick();
    do_op(3'd3, 12'h800, 12'h00F, 12'd4,   12'hF80, 12'h000, 1'b1, 5,  0, "asr 4");
    tick();
    do_op(3'd4, 12'h800, 12'h00F, 12'd4,   12'h080, 12'h000, 1'b1, 5,  0, "lsr 4");
    tick();
    do_op(3'd2, 12'h801, 12'h001, 12'd30,  12'h000, 12'h000, 1'b1, 25, 0, "shl saturated");
    tick();
    do_op(3'd3, 12'h800, 12'h000, 12'd24,  12'hFFF, 12'hFFF, 1'b1, 25, 0, "asr 24");
    tick();
    do_op(3'd2, 12'h5A5, 12'h3C3, 12'h040, 12'h5A5, 12'h3C3, 1'b0, 1,  0, "shl count 0");
    tick();
    do_op(3'd5, 12'h1E1, 12'h2D2, 12'h003, 12'h1E1, 12'h2D2, 1'b0, 1,  0, "undefined op");
    tick();
    do_op(3'd0, 12'd0,   12'd100, 12'd50,  12'd1,   12'd904, 1'b0, 13, 5, "start ignored in run");
    tick();

    // Abort a multiply with reset sampled at edge k+5.
    bus.start = 1'b1; bus.op = EAE_MUL;
    bus.ac_in = 12'd0; bus.mq_in = 12'd100; bus.operand = 12'd50;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort outputs", 64'({bus.busy, bus.done, bus.ac_out, bus.mq_out, bus.link_out}), 64'(0));
    dn = 0;
    repeat (16) begin
      tick();
      if (bus.done !== 1'b0) dn++;
    end
    check("no done after abort", 64'(dn), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
